// File: rtl/csi_pkg.sv
// Shared types, constants and header-ECC helpers for the CSI-2 slave protocol layer.
package csi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_CRC,
      ST_DISCARD
   } csi_state_e;

   // Data types 0x00-0x0F are short packets; everything above carries a payload.
   localparam logic [5:0]  DT_SHORT_MAX  = 6'h0F;

   // x^16+x^12+x^5+1 (0x1021) bit-reversed for LSB-first processing.
   localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
   localparam logic [15:0] CRC_SEED      = 16'hFFFF;

   // Parity masks over {WC[15:0], DI[7:0]}; index k selects parity bit P[k].
   localparam logic [5:0][23:0] ECC_MASK = {
      24'hEFFC00,
      24'hDF03F0,
      24'hB8E38E,
      24'h749A6D,
      24'hF2555B,
      24'hF12CB7
   };

   function automatic logic [5:0] ecc_syndrome(input logic [23:0] data,
                                               input logic [5:0]  ecc);
      logic [5:0] par;
      for (int k = 0; k < 6; k++) par[k] = ^(data & ECC_MASK[k]);
      return par ^ ecc;
   endfunction

endpackage

// File: rtl/csi_crc16.sv
// Byte-wide reflected CRC-16 accumulator; init has priority over enable.
module csi_crc16
   import csi_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        init_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d, nxt;

   always_comb begin
      nxt = crc_q ^ {8'h00, byte_i};
      for (int i = 0; i < 8; i++) nxt = nxt[0] ? ((nxt >> 1) ^ CRC_POLY_REFL) : (nxt >> 1);
      crc_d = crc_q;
      if (init_i)    crc_d = CRC_SEED;
      else if (en_i) crc_d = nxt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) crc_q <= CRC_SEED;
      else         crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/csi_slave_protocol_layer.sv
// CSI-2 packet parser: header ECC decode, payload forwarding, CRC check, truncation handling.
module csi_slave_protocol_layer
   import csi_pkg::*;
(
   input  logic        hs_clk,
   input  logic        rst_n,
   input  logic        rx_active_hs,
   input  logic        rx_sync_hs,
   input  logic        rx_valid_hs,
   input  logic [7:0]  rx_byte_hs,
   output logic        hdr_valid,
   output logic [7:0]  hdr_di,
   output logic [15:0] hdr_wc,
   output logic        ecc_corr,
   output logic        ecc_err,
   output logic        data_valid,
   output logic [7:0]  data_byte,
   output logic        data_last,
   output logic        crc_err,
   output logic        pkt_done,
   output logic        trunc_err
);

   csi_state_e  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] wc_cnt_q, wc_cnt_d;
   logic [7:0]  di_q, di_d, wcl_q, wcl_d, wch_q, wch_d, crc_lo_q, crc_lo_d;
   logic        hdr_valid_q, hdr_valid_d, ecc_corr_q, ecc_corr_d, ecc_err_q, ecc_err_d;
   logic [7:0]  hdr_di_q, hdr_di_d, data_byte_q, data_byte_d;
   logic [15:0] hdr_wc_q, hdr_wc_d;
   logic        data_valid_q, data_valid_d, data_last_q, data_last_d;
   logic        crc_err_q, crc_err_d, pkt_done_q, pkt_done_d, trunc_err_q, trunc_err_d;

   logic        crc_init, crc_en, in_pkt, syn_hit;
   logic [15:0] crc_val;
   logic [23:0] hdr_raw, hdr_fix;
   logic [5:0]  syn, col;

   csi_crc16 u_crc (
      .clk_i  (hs_clk),
      .rst_ni (rst_n),
      .init_i (crc_init),
      .en_i   (crc_en),
      .byte_i (rx_byte_hs),
      .crc_o  (crc_val)
   );

   // Header decode runs on the ECC byte as it arrives; the three earlier bytes are already held.
   always_comb begin
      hdr_raw = {wch_q, wcl_q, di_q};
      syn     = ecc_syndrome(hdr_raw, rx_byte_hs[5:0]);
      hdr_fix = hdr_raw;
      col     = '0;
      syn_hit = (syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0);
      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < 6; k++) col[k] = ECC_MASK[k][i];
         if (syn == col) begin
            hdr_fix[i] = ~hdr_raw[i];
            syn_hit    = 1'b1;
         end
      end
   end

   assign in_pkt = ((state_q == ST_HDR) && (cnt_q != 2'd0)) ||
                   (state_q == ST_PAYLOAD) || (state_q == ST_CRC);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wc_cnt_d     = wc_cnt_q;
      di_d         = di_q;
      wcl_d        = wcl_q;
      wch_d        = wch_q;
      crc_lo_d     = crc_lo_q;
      hdr_di_d     = hdr_di_q;
      hdr_wc_d     = hdr_wc_q;
      data_byte_d  = data_byte_q;
      hdr_valid_d  = 1'b0;
      ecc_corr_d   = 1'b0;
      ecc_err_d    = 1'b0;
      data_valid_d = 1'b0;
      data_last_d  = 1'b0;
      crc_err_d    = 1'b0;
      pkt_done_d   = 1'b0;
      trunc_err_d  = 1'b0;
      crc_init     = 1'b0;
      crc_en       = 1'b0;

      if ((state_q != ST_IDLE) && !rx_active_hs) begin
         state_d     = ST_IDLE;
         cnt_d       = 2'd0;
         trunc_err_d = in_pkt;
      end else if (rx_sync_hs) begin
         state_d     = ST_HDR;
         cnt_d       = 2'd0;
         trunc_err_d = in_pkt;
      end else if (rx_valid_hs) begin
         case (state_q)
            ST_HDR: begin
               cnt_d = cnt_q + 2'd1;
               case (cnt_q)
                  2'd0: di_d  = rx_byte_hs;
                  2'd1: wcl_d = rx_byte_hs;
                  2'd2: wch_d = rx_byte_hs;
                  default: begin
                     if ((syn == 6'd0) || syn_hit) begin
                        hdr_valid_d = 1'b1;
                        ecc_corr_d  = (syn != 6'd0);
                        hdr_di_d    = hdr_fix[7:0];
                        hdr_wc_d    = hdr_fix[23:8];
                        if (hdr_fix[5:0] <= DT_SHORT_MAX) begin
                           pkt_done_d = 1'b1;
                        end else begin
                           crc_init = 1'b1;
                           wc_cnt_d = hdr_fix[23:8];
                           state_d  = (hdr_fix[23:8] == 16'd0) ? ST_CRC : ST_PAYLOAD;
                        end
                     end else begin
                        ecc_err_d = 1'b1;
                        state_d   = ST_DISCARD;
                     end
                  end
               endcase
            end
            ST_PAYLOAD: begin
               data_valid_d = 1'b1;
               data_byte_d  = rx_byte_hs;
               data_last_d  = (wc_cnt_q == 16'd1);
               crc_en       = 1'b1;
               wc_cnt_d     = wc_cnt_q - 16'd1;
               if (wc_cnt_q == 16'd1) state_d = ST_CRC;
            end
            ST_CRC: begin
               if (cnt_q == 2'd0) begin
                  crc_lo_d = rx_byte_hs;
                  cnt_d    = 2'd1;
               end else begin
                  pkt_done_d = 1'b1;
                  crc_err_d  = ({rx_byte_hs, crc_lo_q} != crc_val);
                  cnt_d      = 2'd0;
                  state_d    = ST_HDR;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge hs_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 2'd0;
         wc_cnt_q     <= 16'd0;
         di_q         <= 8'd0;
         wcl_q        <= 8'd0;
         wch_q        <= 8'd0;
         crc_lo_q     <= 8'd0;
         hdr_valid_q  <= 1'b0;
         hdr_di_q     <= 8'd0;
         hdr_wc_q     <= 16'd0;
         ecc_corr_q   <= 1'b0;
         ecc_err_q    <= 1'b0;
         data_valid_q <= 1'b0;
         data_byte_q  <= 8'd0;
         data_last_q  <= 1'b0;
         crc_err_q    <= 1'b0;
         pkt_done_q   <= 1'b0;
         trunc_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wc_cnt_q     <= wc_cnt_d;
         di_q         <= di_d;
         wcl_q        <= wcl_d;
         wch_q        <= wch_d;
         crc_lo_q     <= crc_lo_d;
         hdr_valid_q  <= hdr_valid_d;
         hdr_di_q     <= hdr_di_d;
         hdr_wc_q     <= hdr_wc_d;
         ecc_corr_q   <= ecc_corr_d;
         ecc_err_q    <= ecc_err_d;
         data_valid_q <= data_valid_d;
         data_byte_q  <= data_byte_d;
         data_last_q  <= data_last_d;
         crc_err_q    <= crc_err_d;
         pkt_done_q   <= pkt_done_d;
         trunc_err_q  <= trunc_err_d;
      end
   end

   assign hdr_valid  = hdr_valid_q;
   assign hdr_di     = hdr_di_q;
   assign hdr_wc     = hdr_wc_q;
   assign ecc_corr   = ecc_corr_q;
   assign ecc_err    = ecc_err_q;
   assign data_valid = data_valid_q;
   assign data_byte  = data_byte_q;
   assign data_last  = data_last_q;
   assign crc_err    = crc_err_q;
   assign pkt_done   = pkt_done_q;
   assign trunc_err  = trunc_err_q;

endmodule
